// File: rtl/dec_compare_arbiter.sv
// Round-robin arbiter sharing one 8/16/32-bit codeword comparator between two
// decoder requesters, with a one-stage operand pipeline and per-requester mismatch counters.
module dec_compare_arbiter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 clr_cnt,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [31:0]          req0_a,
  input  logic [31:0]          req0_b,
  input  logic [1:0]           req0_width,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [31:0]          req1_a,
  input  logic [31:0]          req1_b,
  input  logic [1:0]           req1_width,
  output logic                 res0_valid,
  output logic                 res1_valid,
  output logic                 res_equal,
  output logic [CNT_WIDTH-1:0] mism_cnt0,
  output logic [CNT_WIDTH-1:0] mism_cnt1
);

  // Handshake: a transfer happens on a rising edge where reqN_valid & reqN_ready;
  // ready is a pure function of valid, en and last_grant, never high without valid.
  logic                 last_grant_q, last_grant_d;
  logic                 s1_valid_q, s1_valid_d;
  logic                 s1_id_q, s1_id_d;
  logic [31:0]          s1_a_q, s1_a_d;
  logic [31:0]          s1_b_q, s1_b_d;
  logic [1:0]           s1_width_q, s1_width_d;
  logic                 res0_valid_q, res0_valid_d;
  logic                 res1_valid_q, res1_valid_d;
  logic                 res_equal_q, res_equal_d;
  logic [CNT_WIDTH-1:0] cnt0_q, cnt0_d;
  logic [CNT_WIDTH-1:0] cnt1_q, cnt1_d;

  logic grant0, grant1, xfer0, xfer1, s1_eq, inc0, inc1;

  always_comb begin
    grant0 = en & req0_valid & (~req1_valid | last_grant_q);
    grant1 = en & req1_valid & (~req0_valid | ~last_grant_q);
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign xfer0      = req0_valid & grant0;
  assign xfer1      = req1_valid & grant1;

  always_comb begin
    if (s1_width_q[1])
      s1_eq = (s1_a_q == s1_b_q);
    else if (s1_width_q[0])
      s1_eq = (s1_a_q[15:0] == s1_b_q[15:0]);
    else
      s1_eq = (s1_a_q[7:0] == s1_b_q[7:0]);
  end

  always_comb begin
    last_grant_d = last_grant_q;
    s1_valid_d   = xfer0 | xfer1;
    s1_id_d      = s1_id_q;
    s1_a_d       = s1_a_q;
    s1_b_d       = s1_b_q;
    s1_width_d   = s1_width_q;
    if (xfer0) begin
      last_grant_d = 1'b0;
      s1_id_d      = 1'b0;
      s1_a_d       = req0_a;
      s1_b_d       = req0_b;
      s1_width_d   = req0_width;
    end else if (xfer1) begin
      last_grant_d = 1'b1;
      s1_id_d      = 1'b1;
      s1_a_d       = req1_a;
      s1_b_d       = req1_b;
      s1_width_d   = req1_width;
    end
  end

  always_comb begin
    res0_valid_d = s1_valid_q & ~s1_id_q;
    res1_valid_d = s1_valid_q & s1_id_q;
    res_equal_d  = s1_valid_q ? s1_eq : res_equal_q;
    inc0         = res0_valid_d & ~s1_eq & ~(&cnt0_q);
    inc1         = res1_valid_d & ~s1_eq & ~(&cnt1_q);
    cnt0_d       = cnt0_q;
    cnt1_d       = cnt1_q;
    // Clear takes priority over a same-edge increment.
    if (clr_cnt) begin
      cnt0_d = '0;
      cnt1_d = '0;
    end else begin
      if (inc0) cnt0_d = cnt0_q + CNT_WIDTH'(1);
      if (inc1) cnt1_d = cnt1_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= 1'b1;
      s1_valid_q   <= 1'b0;
      s1_id_q      <= 1'b0;
      s1_a_q       <= '0;
      s1_b_q       <= '0;
      s1_width_q   <= '0;
      res0_valid_q <= 1'b0;
      res1_valid_q <= 1'b0;
      res_equal_q  <= 1'b0;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      s1_valid_q   <= s1_valid_d;
      s1_id_q      <= s1_id_d;
      s1_a_q       <= s1_a_d;
      s1_b_q       <= s1_b_d;
      s1_width_q   <= s1_width_d;
      res0_valid_q <= res0_valid_d;
      res1_valid_q <= res1_valid_d;
      res_equal_q  <= res_equal_d;
      cnt0_q       <= cnt0_d;
      cnt1_q       <= cnt1_d;
    end
  end

  assign res0_valid = res0_valid_q;
  assign res1_valid = res1_valid_q;
  assign res_equal  = res_equal_q;
  assign mism_cnt0  = cnt0_q;
  assign mism_cnt1  = cnt1_q;

endmodule

// File: tb/tb_dec_compare_arbiter.sv
// Directed vector bench for dec_compare_arbiter: a table of per-cycle stimulus with
// hand-computed readies and registered outputs, plus saturation and reset sequences.
module tb_dec_compare_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0, clr_cnt = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [1:0]  req0_width = '0, req1_width = '0;
  logic        res0_valid, res1_valid, res_equal;
  logic [15:0] mism_cnt0, mism_cnt1;

  int n_vec = 0;
  int n_err = 0;

  dec_compare_arbiter #(.CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .en(en), .clr_cnt(clr_cnt),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
    .req0_b(req0_b), .req0_width(req0_width),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
    .req1_b(req1_b), .req1_width(req1_width),
    .res0_valid(res0_valid), .res1_valid(res1_valid), .res_equal(res_equal),
    .mism_cnt0(mism_cnt0), .mism_cnt1(mism_cnt1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en, clr, v0;
    logic [31:0] a0, b0;
    logic [1:0]  w0;
    logic        v1;
    logic [31:0] a1, b1;
    logic [1:0]  w1;
    logic        r0, r1, rv0, rv1, eq;
    logic [15:0] c0, c1;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(
    input logic en_, clr_, v0_, input logic [31:0] a0_, b0_, input logic [1:0] w0_,
    input logic v1_, input logic [31:0] a1_, b1_, input logic [1:0] w1_,
    input logic r0_, r1_, rv0_, rv1_, eq_, input logic [15:0] c0_, c1_);
    vec_t v;
    v.en = en_; v.clr = clr_; v.v0 = v0_; v.a0 = a0_; v.b0 = b0_; v.w0 = w0_;
    v.v1 = v1_; v.a1 = a1_; v.b1 = b1_; v.w1 = w1_;
    v.r0 = r0_; v.r1 = r1_; v.rv0 = rv0_; v.rv1 = rv1_; v.eq = eq_;
    v.c0 = c0_; v.c1 = c1_;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive0(input logic v, input logic [31:0] a, b, input logic [1:0] w);
    req0_valid = v; req0_a = a; req0_b = b; req0_width = w;
  endtask

  task automatic drive1(input logic v, input logic [31:0] a, b, input logic [1:0] w);
    req1_valid = v; req1_a = a; req1_b = b; req1_width = w;
  endtask

  initial begin
    // Columns: en clr | v0 a0 b0 w0 | v1 a1 b1 w1 | ready0 ready1 | after edge: rv0 rv1 eq c0 c1
    vecs[0]  = mk(1,0, 1,32'h12345678,32'h12345678,2'b10, 0,0,0,2'b00, 1,0, 0,0,0, 0,0);
    vecs[1]  = mk(1,0, 0,0,0,2'b00, 0,0,0,2'b00,                       0,0, 1,0,1, 0,0);
    vecs[2]  = mk(1,0, 0,0,0,2'b00, 1,32'hFFFF00AA,32'h000000AA,2'b00, 0,1, 0,0,1, 0,0);
    vecs[3]  = mk(1,0, 0,0,0,2'b00, 1,32'hFFFF00AA,32'h000000AA,2'b01, 0,1, 0,1,1, 0,0);
    vecs[4]  = mk(1,0, 0,0,0,2'b00, 1,32'hFFFF00AA,32'h000000AA,2'b11, 0,1, 0,1,1, 0,0);
    vecs[5]  = mk(1,0, 0,0,0,2'b00, 0,0,0,2'b00,                       0,0, 0,1,0, 0,1);
    vecs[6]  = mk(1,1, 1,32'h1,32'h2,2'b10, 1,32'h3,32'h4,2'b10,        1,0, 0,0,0, 0,0);
    vecs[7]  = mk(1,0, 1,32'h1,32'h2,2'b10, 1,32'h3,32'h4,2'b10,        0,1, 1,0,0, 1,0);
    vecs[8]  = mk(1,0, 1,32'h1,32'h2,2'b10, 1,32'h3,32'h4,2'b10,        1,0, 0,1,0, 1,1);
    vecs[9]  = mk(1,0, 1,32'h1,32'h2,2'b10, 1,32'h3,32'h4,2'b10,        0,1, 1,0,0, 2,1);
    vecs[10] = mk(1,0, 0,0,0,2'b00, 0,0,0,2'b00,                       0,0, 0,1,0, 2,2);
    vecs[11] = mk(0,0, 1,32'h5,32'h5,2'b00, 1,32'h3,32'h4,2'b10,        0,0, 0,0,0, 2,2);
    vecs[12] = mk(0,0, 1,32'h5,32'h5,2'b00, 1,32'h3,32'h4,2'b10,        0,0, 0,0,0, 2,2);
    vecs[13] = mk(1,0, 1,32'h5,32'h5,2'b00, 1,32'h3,32'h4,2'b10,        1,0, 0,0,0, 2,2);
    vecs[14] = mk(0,0, 0,0,0,2'b00, 1,32'h3,32'h4,2'b10,               0,0, 1,0,1, 2,2);
    vecs[15] = mk(1,0, 0,0,0,2'b00, 0,0,0,2'b00,                       0,0, 0,0,1, 2,2);

    repeat (2) @(posedge clk);
    #1;
    chk("reset res0_valid", res0_valid, 0);
    chk("reset res1_valid", res1_valid, 0);
    chk("reset res_equal", res_equal, 0);
    chk("reset cnt0", mism_cnt0, 0);
    chk("reset cnt1", mism_cnt1, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      en = vecs[i].en; clr_cnt = vecs[i].clr;
      drive0(vecs[i].v0, vecs[i].a0, vecs[i].b0, vecs[i].w0);
      drive1(vecs[i].v1, vecs[i].a1, vecs[i].b1, vecs[i].w1);
      #1;
      chk($sformatf("v%0d ready0", i), req0_ready, vecs[i].r0);
      chk($sformatf("v%0d ready1", i), req1_ready, vecs[i].r1);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d res0_valid", i), res0_valid, vecs[i].rv0);
      chk($sformatf("v%0d res1_valid", i), res1_valid, vecs[i].rv1);
      chk($sformatf("v%0d res_equal", i), res_equal, vecs[i].eq);
      chk($sformatf("v%0d cnt0", i), mism_cnt0, vecs[i].c0);
      chk($sformatf("v%0d cnt1", i), mism_cnt1, vecs[i].c1);
    end

    // Saturation: clear, then stream requester-0 mismatches back to back.
    @(negedge clk);
    clr_cnt = 1'b1;
    @(negedge clk);
    clr_cnt = 1'b0;
    drive0(1, 32'h1, 32'h2, 2'b10);
    repeat (65534) @(posedge clk);
    @(negedge clk);
    drive0(0, 0, 0, 2'b00);
    repeat (2) @(posedge clk);
    #1;
    chk("sat preload cnt0", mism_cnt0, 16'hFFFE);
    @(negedge clk);
    drive0(1, 32'h1, 32'h2, 2'b10);
    repeat (3) @(posedge clk);
    @(negedge clk);
    drive0(0, 0, 0, 2'b00);
    repeat (2) @(posedge clk);
    #1;
    chk("sat cnt0", mism_cnt0, 16'hFFFF);

    // Clear in the same cycle as a mismatch result: clear wins.
    @(negedge clk);
    drive0(1, 32'h1, 32'h2, 2'b10);
    @(posedge clk);
    @(negedge clk);
    drive0(0, 0, 0, 2'b00);
    clr_cnt = 1'b1;
    @(posedge clk);
    #1;
    chk("clr res0_valid", res0_valid, 1);
    chk("clr cnt0", mism_cnt0, 0);
    @(negedge clk);
    clr_cnt = 1'b0;

    // Reset mid-flight: build non-reset state, transfer, then reset before the result edge.
    drive1(1, 32'h10, 32'h20, 2'b10);
    @(posedge clk);
    @(negedge clk);
    drive1(0, 0, 0, 2'b00);
    drive0(1, 32'hABCD, 32'hABCD, 2'b10);
    @(posedge clk);
    @(negedge clk);
    drive0(0, 0, 0, 2'b00);
    @(posedge clk);
    #1;
    chk("pre-rst res_equal", res_equal, 1);
    chk("pre-rst cnt1", mism_cnt1, 1);
    @(negedge clk);
    drive0(1, 32'h1, 32'h2, 2'b10);
    @(posedge clk);
    @(negedge clk);
    drive0(0, 0, 0, 2'b00);
    rst = 1'b1;
    #1;
    chk("rst res0_valid", res0_valid, 0);
    chk("rst res1_valid", res1_valid, 0);
    chk("rst res_equal", res_equal, 0);
    chk("rst cnt0", mism_cnt0, 0);
    chk("rst cnt1", mism_cnt1, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("post-rst %0d res0_valid", k), res0_valid, 0);
      chk($sformatf("post-rst %0d cnt0", k), mism_cnt0, 0);
    end
    @(negedge clk);
    drive0(1, 32'h1, 32'h1, 2'b10);
    drive1(1, 32'h1, 32'h1, 2'b10);
    #1;
    chk("post-rst ready0", req0_ready, 1);
    chk("post-rst ready1", req1_ready, 0);
    @(negedge clk);
    drive0(0, 0, 0, 2'b00);
    drive1(0, 0, 0, 2'b00);
    repeat (2) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dec_compare_arbiter.md
Name: dec_compare_arbiter

Overview:
Shares one multi-width codeword comparator (8/16/32-bit) between two decoder requesters, e.g. the syndrome-check path (requester 0) and the scrub/readback path (requester 1).
Arbitration is round-robin with a valid/ready handshake. Operands and the comparison result are pipelined through registers. Each result is returned to the requester that issued it.
Keeps a saturating mismatch counter per requester for status readout.

Parameters:
CNT_WIDTH, 16, width of each per-requester mismatch counter.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  reset, asynchronous, active-high.
en  input  1  arbitration enable; low blocks new grants, in-flight compare still completes.
clr_cnt  input  1  synchronous clear of both mismatch counters.
req0_valid  input  1  requester 0 has an operand pair.
req0_ready  output  1  requester 0 transfer accepted this cycle.
req0_a  input  32  requester 0 operand A.
req0_b  input  32  requester 0 operand B.
req0_width  input  2  requester 0 codeword width: 2'b1x = 32-bit, 2'b01 = 16-bit, 2'b00 = 8-bit.
req1_valid, req1_ready, req1_a, req1_b, req1_width  same directions, widths and meanings for requester 1.
res0_valid  output  1  one-cycle pulse: result for requester 0.
res1_valid  output  1  one-cycle pulse: result for requester 1.
res_equal  output  1  comparison result, qualified by res0_valid or res1_valid.
mism_cnt0  output  CNT_WIDTH  requester 0 mismatch count.
mism_cnt1  output  CNT_WIDTH  requester 1 mismatch count.

Behaviour:
- Reset values: last_grant = 1 (requester 0 has first priority), stage-1 valid = 0, res0_valid = res1_valid = 0, res_equal = 0, mism_cnt0 = mism_cnt1 = 0.
- Grant logic is combinational from req*_valid, en and last_grant:
  - en = 0: both ready low.
  - Exactly one requester valid: that requester is granted.
  - Both valid: the requester other than last_grant is granted.
  - reqN_ready = grant N. At most one ready is high in any cycle.
  - Readies are never asserted without the matching valid.
- Transfer occurs when reqN_valid & reqN_ready at a rising edge T0. At T0:
  - A, B, width and the requester id are latched into stage 1; stage-1 valid is set.
  - last_grant is set to N. last_grant is unchanged in cycles with no transfer.
- No backpressure on results, so throughput is one transfer per cycle. Back-to-back transfers are legal, and the two requesters alternate when both are held valid.
- Stage-1 compare (combinational):
  - width[1] = 1: A[31:0] == B[31:0].
  - width = 2'b01: A[15:0] == B[15:0].
  - width = 2'b00: A[7:0] == B[7:0].
  - Bits above the selected width are ignored.
- At edge T1 (the edge after T0):
  - res_equal is registered.
  - resN_valid is set for the latched id, for exactly one cycle, unless another stage-1 entry follows.
  - Latency is 2 edges from transfer to visible result.
  - res_equal holds its last value while both result valids are low.
- Counters:
  - mism_cntN increments by 1 at the edge where resN_valid is registered high with equal = 0.
  - Counters saturate at all-ones and do not wrap.
  - clr_cnt = 1 clears both counters to 0 at the edge; clear wins over a simultaneous increment.
- en deasserted while a transfer is in stage 1: that result is still delivered at T1.
- Asynchronous reset mid-operation: the in-flight compare is dropped, no result pulse is produced, all state returns to reset values immediately, and requesters must re-present their operands.
- Requester protocol: a requester holds valid and its operands stable until ready is seen. Operand changes without a transfer have no effect.

Test Plan:
1. Reset, then req0 only: A=0x12345678, B=0x12345678, width=2'b10 → req0_ready high in the same cycle; res0_valid pulse 2 edges later; res_equal=1; mism_cnt0=0.
2. Width masking on req1: A=0xFFFF00AA, B=0x000000AA, width=2'b00 → equal=1. Width=2'b01 → equal=1. Width=2'b11 → equal=0 and mism_cnt1=1.
3. Both valid for 4 cycles, every compare a mismatch → grants alternate 0,1,0,1; res valids alternate with 2-edge lag; mism_cnt0=2, mism_cnt1=2.
4. en=0 with both valid → both ready stay low and no result pulses. Raise en → requester 0 is granted first (last_grant=1 from reset).
5. Preload mism_cnt0 to 0xFFFE via mismatches, then apply 3 more mismatches → counter stops at 0xFFFF. Assert clr_cnt in the cycle of another mismatch result → counter reads 0.
6. Assert rst in the cycle after a transfer → no res valid pulse ever appears for that transfer; all outputs read reset values while rst is high.
